// File: rtl/bp_be_branch_resolve.sv
// -----------------------------------------------------------------------------
// bp_be_branch_resolve
//
// Purpose:
//   Sits behind the control pipe of the BE calculator. Each resolved packet's
//   npc is compared with the npc the frontend actually fetched. A mismatch
//   registers a redirect command for the FE command queue, pulses a one-cycle
//   squash of younger work, and holds the command until it is accepted.
//   Saturating branch and mispredict statistics are kept.
//
// Optional feature (macro BP_BE_BRANCH_RESOLVE_ATTABOY_EN):
//   When defined, a correctly predicted control-flow instruction produces a
//   one-cycle, non-stalling "attaboy" command. When undefined, the attaboy
//   output is tied to 0.
//
// Ports:
//   clk_i                clock, rising edge
//   reset_i              asynchronous active-low reset
//   br_v_i               resolved packet valid
//   br_branch_i          packet is a control-flow instruction
//   br_btaken_i          control-flow instruction resolved taken
//   br_npc_i             resolved next pc
//   pred_npc_i           npc actually fetched by the frontend
//   fe_cmd_v_o           command valid toward the FE command queue
//   fe_cmd_npc_o         command target pc
//   fe_cmd_taken_o       taken bit of the resolving instruction
//   fe_cmd_branch_o      command caused by a control-flow instruction
//   fe_cmd_attaboy_o     command is a correct-prediction notice
//   fe_cmd_ready_and_i   FE command queue accepts when valid & ready
//   flush_o              one-cycle squash of younger instructions
//   busy_o               redirect outstanding, issue must stall
//   branch_cnt_o         saturating count of accepted control-flow packets
//   mispredict_cnt_o     saturating count of redirects
//
// State table:
//   state      | meaning
//   E_IDLE     | packets accepted and checked; attaboy (if enabled) lasts 1 cycle
//   E_REDIRECT | redirect command held until accepted; packets are squashed
// -----------------------------------------------------------------------------
module bp_be_branch_resolve #(
  parameter int vaddr_width_p = 39,
  parameter int stat_width_p  = 32
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     br_v_i,
  input  logic                     br_branch_i,
  input  logic                     br_btaken_i,
  input  logic [vaddr_width_p-1:0] br_npc_i,
  input  logic [vaddr_width_p-1:0] pred_npc_i,
  output logic                     fe_cmd_v_o,
  output logic [vaddr_width_p-1:0] fe_cmd_npc_o,
  output logic                     fe_cmd_taken_o,
  output logic                     fe_cmd_branch_o,
  output logic                     fe_cmd_attaboy_o,
  input  logic                     fe_cmd_ready_and_i,
  output logic                     flush_o,
  output logic                     busy_o,
  output logic [stat_width_p-1:0]  branch_cnt_o,
  output logic [stat_width_p-1:0]  mispredict_cnt_o
);

  typedef enum logic {E_IDLE, E_REDIRECT} state_e;

  state_e                   state_q, state_d;
  logic                     cmd_v_q, cmd_v_d;
  logic                     flush_q, flush_d;
  logic [vaddr_width_p-1:0] npc_q, npc_d;
  logic                     taken_q, taken_d;
  logic                     branch_q, branch_d;
  logic [stat_width_p-1:0]  br_cnt_q, br_cnt_d;
  logic [stat_width_p-1:0]  mp_cnt_q, mp_cnt_d;
`ifdef BP_BE_BRANCH_RESOLVE_ATTABOY_EN
  logic                     attaboy_q, attaboy_d;
`endif

  logic mismatch;
  assign mismatch = (br_npc_i != pred_npc_i);

  always_comb begin
    state_d   = state_q;
    cmd_v_d   = cmd_v_q;
    flush_d   = 1'b0;
    npc_d     = npc_q;
    taken_d   = taken_q;
    branch_d  = branch_q;
    br_cnt_d  = br_cnt_q;
    mp_cnt_d  = mp_cnt_q;
`ifdef BP_BE_BRANCH_RESOLVE_ATTABOY_EN
    attaboy_d = 1'b0;
`endif
    case (state_q)
      E_IDLE: begin
        // Any command shown in an IDLE cycle is an attaboy, which is
        // offered once and then dropped regardless of ready.
        cmd_v_d = 1'b0;
        if (br_v_i) begin
          if (br_branch_i && (br_cnt_q != '1)) begin
            br_cnt_d = br_cnt_q + stat_width_p'(1);
          end
          if (mismatch) begin
            state_d  = E_REDIRECT;
            cmd_v_d  = 1'b1;
            flush_d  = 1'b1;
            npc_d    = br_npc_i;
            taken_d  = br_btaken_i;
            branch_d = br_branch_i;
            if (mp_cnt_q != '1) begin
              mp_cnt_d = mp_cnt_q + stat_width_p'(1);
            end
          end
`ifdef BP_BE_BRANCH_RESOLVE_ATTABOY_EN
          else if (br_branch_i) begin
            cmd_v_d   = 1'b1;
            attaboy_d = 1'b1;
            npc_d     = br_npc_i;
            taken_d   = br_btaken_i;
            branch_d  = 1'b1;
          end
`endif
        end
      end
      E_REDIRECT: begin
        // Younger packets are squashed here and never counted.
        if (fe_cmd_ready_and_i) begin
          state_d = E_IDLE;
          cmd_v_d = 1'b0;
        end
      end
      default: begin
        state_d = E_IDLE;
        cmd_v_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q   <= E_IDLE;
      cmd_v_q   <= 1'b0;
      flush_q   <= 1'b0;
      npc_q     <= '0;
      taken_q   <= 1'b0;
      branch_q  <= 1'b0;
      br_cnt_q  <= '0;
      mp_cnt_q  <= '0;
`ifdef BP_BE_BRANCH_RESOLVE_ATTABOY_EN
      attaboy_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cmd_v_q   <= cmd_v_d;
      flush_q   <= flush_d;
      npc_q     <= npc_d;
      taken_q   <= taken_d;
      branch_q  <= branch_d;
      br_cnt_q  <= br_cnt_d;
      mp_cnt_q  <= mp_cnt_d;
`ifdef BP_BE_BRANCH_RESOLVE_ATTABOY_EN
      attaboy_q <= attaboy_d;
`endif
    end
  end

  // All outputs come straight from registers; no input-to-output paths.
  assign fe_cmd_v_o       = cmd_v_q;
  assign fe_cmd_npc_o     = npc_q;
  assign fe_cmd_taken_o   = taken_q;
  assign fe_cmd_branch_o  = branch_q;
  assign flush_o          = flush_q;
  assign busy_o           = (state_q == E_REDIRECT);
  assign branch_cnt_o     = br_cnt_q;
  assign mispredict_cnt_o = mp_cnt_q;
`ifdef BP_BE_BRANCH_RESOLVE_ATTABOY_EN
  assign fe_cmd_attaboy_o = attaboy_q;
`else
  assign fe_cmd_attaboy_o = 1'b0;
`endif

endmodule

// File: tb/tb_bp_be_branch_resolve.sv
// -----------------------------------------------------------------------------
// tb_bp_be_branch_resolve
//
// Scoreboard bench for bp_be_branch_resolve. The driver applies one packet per
// cycle, keeps a transaction-level model (busy flag, statistics, expected
// command list) and pushes each expected command with the cycle it must appear.
// A negedge monitor pops and compares commands, flush/busy and statistics.
// Honours BP_BE_BRANCH_RESOLVE_ATTABOY_EN when defined.
// -----------------------------------------------------------------------------
module tb_bp_be_branch_resolve;

  localparam int VW  = 39;
  localparam int SW  = 4;
  localparam int SAT = (1 << SW) - 1;

  logic          clk_i = 1'b0;
  logic          reset_i = 1'b0;
  logic          br_v_i = 1'b0;
  logic          br_branch_i = 1'b0;
  logic          br_btaken_i = 1'b0;
  logic [VW-1:0] br_npc_i = '0;
  logic [VW-1:0] pred_npc_i = '0;
  logic          fe_cmd_v_o;
  logic [VW-1:0] fe_cmd_npc_o;
  logic          fe_cmd_taken_o;
  logic          fe_cmd_branch_o;
  logic          fe_cmd_attaboy_o;
  logic          fe_cmd_ready_and_i = 1'b0;
  logic          flush_o;
  logic          busy_o;
  logic [SW-1:0] branch_cnt_o;
  logic [SW-1:0] mispredict_cnt_o;

  bp_be_branch_resolve #(.vaddr_width_p(VW), .stat_width_p(SW)) dut (
    .clk_i              (clk_i),
    .reset_i            (reset_i),
    .br_v_i             (br_v_i),
    .br_branch_i        (br_branch_i),
    .br_btaken_i        (br_btaken_i),
    .br_npc_i           (br_npc_i),
    .pred_npc_i         (pred_npc_i),
    .fe_cmd_v_o         (fe_cmd_v_o),
    .fe_cmd_npc_o       (fe_cmd_npc_o),
    .fe_cmd_taken_o     (fe_cmd_taken_o),
    .fe_cmd_branch_o    (fe_cmd_branch_o),
    .fe_cmd_attaboy_o   (fe_cmd_attaboy_o),
    .fe_cmd_ready_and_i (fe_cmd_ready_and_i),
    .flush_o            (flush_o),
    .busy_o             (busy_o),
    .branch_cnt_o       (branch_cnt_o),
    .mispredict_cnt_o   (mispredict_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [VW-1:0] npc;
    logic          taken;
    logic          branch;
    logic          attaboy;
    int            due;
  } cmd_t;

  cmd_t q[$];
  cmd_t held;
  logic pending = 1'b0;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  // Transaction-level model state
  logic m_busy = 1'b0;
  int   m_br = 0, m_mp = 0;
  int   seen_br = 0, seen_mp = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One packet per cycle: drive just after the rising edge and update the model.
  task automatic cycle(input logic v, input logic br, input logic tk,
                       input logic [VW-1:0] npc, input logic [VW-1:0] pred,
                       input logic rdy);
    logic ignored;
    cmd_t c;
    @(posedge clk_i);
    #1;
    seen_br = m_br;
    seen_mp = m_mp;
    br_v_i = v; br_branch_i = br; br_btaken_i = tk;
    br_npc_i = npc; pred_npc_i = pred; fe_cmd_ready_and_i = rdy;
    ignored = m_busy;
    if (m_busy && rdy) m_busy = 1'b0;
    if (!ignored && v) begin
      if (br) m_br = (m_br < SAT) ? m_br + 1 : SAT;
      if (npc != pred) begin
        c.npc = npc; c.taken = tk; c.branch = br; c.attaboy = 1'b0; c.due = cyc + 1;
        q.push_back(c);
        m_mp = (m_mp < SAT) ? m_mp + 1 : SAT;
        m_busy = 1'b1;
      end
`ifdef BP_BE_BRANCH_RESOLVE_ATTABOY_EN
      else if (br) begin
        c.npc = npc; c.taken = tk; c.branch = 1'b1; c.attaboy = 1'b1; c.due = cyc + 1;
        q.push_back(c);
      end
`endif
    end
  endtask

  task automatic idle(input logic rdy);
    cycle(1'b0, 1'b0, 1'b0, '0, '0, rdy);
  endtask

  function automatic logic [VW-1:0] rnd_pc();
    return VW'({$urandom(), $urandom()}) & ~VW'(1);
  endfunction

  // Monitor
  always @(negedge clk_i) begin
    cmd_t e;
    logic redirect_now;
    if (reset_i) begin
      redirect_now = 1'b0;
      chk("branch_cnt", 64'(branch_cnt_o), 64'(seen_br));
      chk("mispredict_cnt", 64'(mispredict_cnt_o), 64'(seen_mp));
      while (q.size() != 0 && q[0].due < cyc) begin
        checks++; errors++;
        $display("FAIL missing_cmd actual=none expected npc=%0h due=%0d", q[0].npc, q[0].due);
        void'(q.pop_front());
      end
      if (pending) begin
        redirect_now = 1'b1;
        chk("held_v", 64'(fe_cmd_v_o), 64'd1);
        chk("held_npc", 64'(fe_cmd_npc_o), 64'(held.npc));
        chk("held_taken", 64'(fe_cmd_taken_o), 64'(held.taken));
        chk("held_branch", 64'(fe_cmd_branch_o), 64'(held.branch));
        chk("held_attaboy", 64'(fe_cmd_attaboy_o), 64'd0);
        chk("held_flush", 64'(flush_o), 64'd0);
        chk("held_busy", 64'(busy_o), 64'd1);
      end else if (fe_cmd_v_o) begin
        if (q.size() == 0 || q[0].due != cyc) begin
          checks++; errors++;
          $display("FAIL spurious_cmd actual npc=%0h expected=none", fe_cmd_npc_o);
        end else begin
          e = q.pop_front();
          held = e;
          redirect_now = !e.attaboy;
          chk("cmd_npc", 64'(fe_cmd_npc_o), 64'(e.npc));
          chk("cmd_taken", 64'(fe_cmd_taken_o), 64'(e.taken));
          chk("cmd_branch", 64'(fe_cmd_branch_o), 64'(e.branch));
          chk("cmd_attaboy", 64'(fe_cmd_attaboy_o), 64'(e.attaboy));
          chk("cmd_flush", 64'(flush_o), 64'(!e.attaboy));
          chk("cmd_busy", 64'(busy_o), 64'(!e.attaboy));
        end
      end else begin
        chk("idle_flush", 64'(flush_o), 64'd0);
        chk("idle_busy", 64'(busy_o), 64'd0);
      end
      pending = redirect_now && !fe_cmd_ready_and_i;
    end
  end

  task automatic clear_model();
    q.delete();
    pending = 1'b0;
    m_busy = 1'b0;
    m_br = 0; m_mp = 0; seen_br = 0; seen_mp = 0;
  endtask

  initial begin
    logic [VW-1:0] a, b;
    logic v, br, rdy;

    // Reset state
    reset_i = 1'b0;
    #1;
    chk("rst_v", 64'(fe_cmd_v_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_br_cnt", 64'(branch_cnt_o), 64'd0);
    repeat (2) @(posedge clk_i);
    #1 reset_i = 1'b1;

    // Taken mispredict, accepted immediately
    cycle(1, 1, 1, 39'h0_8000_0100, 39'h0_8000_0004, 1);
    idle(1);
    idle(1);

    // Backpressure: 5 cycles not ready with squashed packets, then accept
    cycle(1, 1, 0, 39'h0_0000_4000, 39'h0_0000_4008, 0);
    for (int i = 0; i < 5; i++) cycle(1, 1, 1, rnd_pc(), rnd_pc(), 0);
    cycle(1, 1, 1, 39'h0_0000_7000, 39'h0_0000_7004, 1);
    idle(0);

    // Correct non-branch
    cycle(1, 0, 0, 39'h1004, 39'h1004, 1);
    idle(1);

    // Correct taken branch (attaboy when enabled, ready low), then mismatch
    cycle(1, 1, 1, 39'h2000, 39'h2000, 0);
    cycle(1, 1, 0, 39'h3000, 39'h3004, 0);
    idle(0);
    idle(1);
    idle(1);

    // Reset while a redirect is held and not accepted
    cycle(1, 0, 1, 39'h5000, 39'h5008, 0);
    idle(0);
    @(negedge clk_i);
    #1;
    chk("pre_rst_v", 64'(fe_cmd_v_o), 64'd1);
    reset_i = 1'b0;
    br_v_i = 1'b0; fe_cmd_ready_and_i = 1'b0;
    #1;
    chk("mid_rst_v", 64'(fe_cmd_v_o), 64'd0);
    chk("mid_rst_npc", 64'(fe_cmd_npc_o), 64'd0);
    chk("mid_rst_flush", 64'(flush_o), 64'd0);
    chk("mid_rst_busy", 64'(busy_o), 64'd0);
    chk("mid_rst_taken", 64'(fe_cmd_taken_o), 64'd0);
    chk("mid_rst_branch", 64'(fe_cmd_branch_o), 64'd0);
    chk("mid_rst_br_cnt", 64'(branch_cnt_o), 64'd0);
    chk("mid_rst_mp_cnt", 64'(mispredict_cnt_o), 64'd0);
    clear_model();
    repeat (2) @(posedge clk_i);
    #1 reset_i = 1'b1;
    idle(0);

    // Counter saturation with 20 correctly predicted branches
    for (int i = 0; i < 20; i++) begin
      a = rnd_pc();
      cycle(1, 1, i[0], a, a, 1);
    end
    idle(1);
    @(negedge clk_i);
    chk("sat_branch_cnt", 64'(branch_cnt_o), 64'(SAT));
    idle(1);
    @(negedge clk_i);
    chk("sat_branch_cnt_hold", 64'(branch_cnt_o), 64'(SAT));

    // Randomised traffic
    for (int i = 0; i < 2000; i++) begin
      a = rnd_pc();
      b = ($urandom_range(0, 9) < 6) ? a : rnd_pc();
      v = ($urandom_range(0, 3) != 0);
      br = $urandom_range(0, 1) == 1;
      rdy = ($urandom_range(0, 2) != 0);
      cycle(v, br, $urandom_range(0, 1) == 1, a, b, rdy);
    end

    // Drain
    for (int i = 0; i < 10; i++) idle(1);
    @(negedge clk_i);
    #1;
    chk("drain_queue_empty", 64'(q.size()), 64'd0);
    chk("drain_no_pending", 64'(pending), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
